xillybus_rd_stream_src: RTL and testbench
=========================================

Name: xillybus_rd_stream_src

Overview:
Application-side source for a Xillybus read stream (FPGA-to-host), e.g. the gs_raw_signal channel. It captures a fixed-length block of samples from the acquisition front end into an internal FIFO and serves the core's standard-FIFO read handshake (rden/empty/data/eof). It signals end-of-file once the whole block has been drained. It sits between the signal sampler and the xillybus_core user_r_* ports.

Parameters:
DATA_W, 16, sample and stream word width
DEPTH_LOG2, 10, FIFO depth = 2**DEPTH_LOG2 words
BLOCK_LEN, 1024, samples captured per test (1..65535)

Ports:
bus_clk_w  in  1  single clock, all logic rising-edge
bus_rst_n_w  in  1  asynchronous active-low reset
capture_start  in  1  one-cycle pulse starting a capture block
sample_data  in  DATA_W  sample from front end
sample_valid  in  1  sample_data qualifier
stream_open  in  1  from core user_r_*_open
stream_rden  in  1  from core user_r_*_rden
stream_data  out  DATA_W  to core user_r_*_data
stream_empty  out  1  to core user_r_*_empty
stream_eof  out  1  to core user_r_*_eof
capture_busy  out  1  high in CAPTURE or DRAIN
overflow  out  1  sticky: sample dropped on full FIFO
sample_count  out  16  samples accepted in current block

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, stream_data=0, stream_empty=1, stream_eof=0, capture_busy=0, overflow=0, sample_count=0.
- FSM states IDLE, CAPTURE, DRAIN, DONE.
- IDLE -> CAPTURE: capture_start=1 and stream_open=1. In the same cycle, flush the FIFO and clear sample_count and overflow. capture_start with stream_open=0 is ignored.
- CAPTURE: each cycle with sample_valid=1, write sample_data if the FIFO is not full, or if it is full and stream_rden=1 in the same cycle. Either way, increment sample_count.
  - If the FIFO is full and stream_rden=0, drop the sample, set overflow, and still increment sample_count, so the block length is time-bounded.
  - When the increment makes sample_count == BLOCK_LEN, go to DRAIN on the next cycle. sample_valid is ignored afterwards.
- DRAIN: no writes. When the FIFO is empty, go to DONE.
- DONE: stream_eof=1 (stream_empty also 1). Remains until stream_open=0, then IDLE. Nothing is cleared in DONE, so sample_count and overflow stay readable.
- stream_open falling in any state: next cycle IDLE, FIFO flushed, eof=0, capture_busy=0. overflow and sample_count are held.
- capture_start outside IDLE: ignored.
- Read handshake (standard FIFO, not FWFT):
  - stream_rden=1 with stream_empty=0 pops one word; stream_data updates on the following edge and is held until the next pop.
  - stream_rden while empty: ignored, data held.
- stream_empty is registered. It deasserts one cycle after the first write lands, and asserts in the cycle the last word is popped.
- FIFO: write and read pointers are DEPTH_LOG2+1 bits and wrap naturally. full = MSBs differ and the lower bits are equal; empty = pointers equal.
- Simultaneous read and write: both occur and the count is unchanged.
- sample_count saturates at BLOCK_LEN.
- Throughput: one write and one read per cycle sustained.

Optional Feature:
RAW_SIG_TEST_PATTERN_EN:
- Defined: the written word is a DATA_W-bit counter instead of sample_data. The counter resets to 0 on each capture_start and increments per accepted sample_valid, giving a deterministic ramp for host-side link checks.
- Undefined: sample_data is written unchanged and the counter logic is absent.

Decomposition:
- Package xillybus_stream_pkg: state enum (IDLE, CAPTURE, DRAIN, DONE), default DATA_W/DEPTH_LOG2 constants, sample_count width constant (16).
- Sub-module sync_fifo_ram: simple dual-port register/BRAM array with a registered read port. The pointers and flags stay in the top level.

Test Plan:
- Open=1, capture_start, 1024 back-to-back samples 0x0000..0x03FF, rden held high -> host receives 0x0000..0x03FF in order; eof=1 after the final pop; capture_busy falls at the same time.
- DEPTH_LOG2=4, BLOCK_LEN=32, no rden during capture -> first 16 samples stored, overflow=1, sample_count=32. Draining returns samples 0..15, then eof.
- FIFO full with sample_valid and rden in the same cycle -> write accepted, overflow stays 0, stream_empty stays 0.
- stream_open deasserted mid-CAPTURE with 100 samples queued -> next cycle IDLE, stream_empty=1, eof=0. A new open plus capture_start gives a clean block with no stale data.
- capture_start with stream_open=0, and capture_start during DRAIN -> both ignored; state and sample_count unchanged.
- bus_rst_n_w pulsed low mid-DRAIN -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/xillybus_stream_pkg.sv
// Shared constants for the Xillybus read-stream source.
// FSM encodings, default widths and the sample counter width.
package xillybus_stream_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int DEPTH_LOG2_DEF = 10;
  localparam int CNT_W          = 16;

  typedef logic [1:0] st_t;

  localparam st_t ST_IDLE    = 2'd0;
  localparam st_t ST_CAPTURE = 2'd1;
  localparam st_t ST_DRAIN   = 2'd2;
  localparam st_t ST_DONE    = 2'd3;

endpackage

// File: rtl/xillybus_rd_stream_src_if.sv
// Standard-FIFO read handshake towards xillybus_core user_r_* ports.
// master = this source, slave = core side.
interface xillybus_rd_stream_src_if
  import xillybus_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              stream_open;
  logic              stream_rden;
  logic [DATA_W-1:0] stream_data;
  logic              stream_empty;
  logic              stream_eof;

  modport master (
    input  stream_open,
    input  stream_rden,
    output stream_data,
    output stream_empty,
    output stream_eof
  );

  modport slave (
    output stream_open,
    output stream_rden,
    input  stream_data,
    input  stream_empty,
    input  stream_eof
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage array with a registered read port.
// Pointers and flags live in the instantiating module.
module sync_fifo_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/xillybus_rd_stream_src.sv
// Captures one block of samples into a FIFO and serves the Xillybus read stream.
// RAW_SIG_TEST_PATTERN_EN: write a ramp counter instead of sample_data.
module xillybus_rd_stream_src
  import xillybus_stream_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int BLOCK_LEN  = 1024
) (
  input  logic                bus_clk_w,
  input  logic                bus_rst_n_w,
  input  logic                capture_start,
  input  logic [DATA_W-1:0]   sample_data,
  input  logic                sample_valid,
  xillybus_rd_stream_src_if.master strm,
  output logic                capture_busy,
  output logic                overflow,
  output logic [CNT_W-1:0]    sample_count
);

  localparam int AW = DEPTH_LOG2;
  localparam logic [CNT_W-1:0] BLK = CNT_W'(BLOCK_LEN);

  st_t              state_q, state_d;
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             empty_q;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  logic fifo_empty;
  logic fifo_full;
  logic flush;
  logic pop;
  logic cap_valid;
  logic wr;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign flush = !strm.stream_open ||
                 (state_q == ST_IDLE && capture_start);
  assign pop = strm.stream_rden && !empty_q && !flush;

  assign cap_valid = (state_q == ST_CAPTURE) &&
                     strm.stream_open && sample_valid;
  // A full FIFO still accepts a write when a pop frees a slot this cycle
  assign wr = cap_valid && (!fifo_full || pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wptr_d  = wptr_q + (AW+1)'(wr);
    rptr_d  = rptr_q + (AW+1)'(pop);
    if (!strm.stream_open) begin
      state_d = ST_IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (capture_start) begin
            state_d = ST_CAPTURE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            wptr_d  = '0;
            rptr_d  = '0;
          end
        end
        ST_CAPTURE: begin
          if (sample_valid) begin
            if (!wr) ovf_d = 1'b1;
            if (cnt_q != BLK) cnt_d = cnt_q + 1'b1;
            if (cnt_d == BLK) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
    if (!bus_rst_n_w) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      empty_q <= (wptr_d == rptr_d);
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RAW_SIG_TEST_PATTERN_EN
  logic [DATA_W-1:0] pat_q;

  always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
    if (!bus_rst_n_w) pat_q <= '0;
    else if (state_q == ST_IDLE && strm.stream_open &&
             capture_start) pat_q <= '0;
    else if (cap_valid) pat_q <= pat_q + 1'b1;
  end

  assign wdata = pat_q;
`else
  assign wdata = sample_data;
`endif

  sync_fifo_ram #(
    .DW (DATA_W),
    .AW (AW)
  ) u_ram (
    .clk   (bus_clk_w),
    .rst_n (bus_rst_n_w),
    .we    (wr),
    .waddr (wptr_q[AW-1:0]),
    .wdata (wdata),
    .re    (pop),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rdata)
  );

  assign strm.stream_data  = rdata;
  assign strm.stream_empty = empty_q;
  assign strm.stream_eof   = (state_q == ST_DONE);
  assign capture_busy = (state_q == ST_CAPTURE) ||
                        (state_q == ST_DRAIN);
  assign overflow     = ovf_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_xillybus_rd_stream_src.sv
// Self-checking bench for xillybus_rd_stream_src (small FIFO, short block).
// A queue-based block/stream model supplies every expected value.
module tb_xillybus_rd_stream_src;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int BL    = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] sdata = '0;
  logic        busy;
  logic        ovf;
  logic [15:0] cnt;

  int checks = 0;
  int passed = 0;

  xillybus_rd_stream_src_if #(.DATA_W(16)) sif ();

  xillybus_rd_stream_src #(
    .DATA_W     (16),
    .DEPTH_LOG2 (DL),
    .BLOCK_LEN  (BL)
  ) dut (
    .bus_clk_w     (clk),
    .bus_rst_n_w   (rst_n),
    .capture_start (start),
    .sample_data   (sdata),
    .sample_valid  (valid),
    .strm          (sif.master),
    .capture_busy  (busy),
    .overflow      (ovf),
    .sample_count  (cnt)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_CAP, M_DRAIN, M_DONE} ph_t;
  ph_t         ph = M_IDLE;
  logic [15:0] mq[$];
  logic [15:0] m_data = '0;
  logic [15:0] m_cnt = '0;
  logic        m_ovf = 1'b0;

  function automatic logic [35:0] exp_vec();
    return {m_data, mq.size() == 0, ph == M_DONE,
            ph == M_CAP || ph == M_DRAIN, m_ovf, m_cnt};
  endfunction

  function automatic logic [35:0] act_vec();
    return {sif.stream_data, sif.stream_empty, sif.stream_eof,
            busy, ovf, cnt};
  endfunction

  task automatic model_reset();
    ph = M_IDLE;
    mq.delete();
    m_data = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, return at the negedge
  task automatic step(input bit st, input bit v, input logic [15:0] d,
                      input bit rd, input bit op);
    int sz;
    bit flush;
    bit pop;
    start = st;
    valid = v;
    sdata = d;
    sif.stream_rden = rd;
    sif.stream_open = op;
    @(posedge clk);
    sz = mq.size();
    flush = !op || (ph == M_IDLE && st);
    pop = rd && sz > 0 && !flush;
    if (pop) m_data = mq.pop_front();
    if (!op) begin
      mq.delete();
      ph = M_IDLE;
    end else begin
      case (ph)
        M_IDLE: if (st) begin
          mq.delete();
          m_cnt = '0;
          m_ovf = 1'b0;
          ph = M_CAP;
        end
        M_CAP: if (v) begin
          if (mq.size() < DEPTH) mq.push_back(d);
          else m_ovf = 1'b1;
          m_cnt = m_cnt + 16'd1;
          if (m_cnt == 16'(BL)) ph = M_DRAIN;
        end
        M_DRAIN: if (sz == 0) ph = M_DONE;
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    sif.stream_open = 1'b0;
    sif.stream_rden = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (sif.stream_empty !== 1'b1)
      $display("FAIL rst_empty got %b want 1", sif.stream_empty);
    else passed++;
    checks++;
    if (sif.stream_eof !== 1'b0)
      $display("FAIL rst_eof got %b want 0", sif.stream_eof);
    else passed++;
    checks++;
    if ({busy, ovf} !== 2'b00)
      $display("FAIL rst_busy_ovf got %b want 00", {busy, ovf});
    else passed++;
    checks++;
    if ({sif.stream_data, cnt} !== 32'h0)
      $display("FAIL rst_data_cnt got %h want 0",
               {sif.stream_data, cnt});
    else passed++;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    checks++;
    if (act_vec() !== exp_vec())
      $display("FAIL rst_idle got %h want %h", act_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_stream();
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < BL; i++) begin
      step(0, 1, 16'(i), 1, 1);
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL stream c%0d got %h want %h",
                 i, act_vec(), exp_vec());
      else passed++;
    end
    for (int k = 0; k < 40 && ph != M_DONE; k++) begin
      step(0, 0, 0, 1, 1);
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL stream_drain c%0d got %h want %h",
                 k, act_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if ({sif.stream_eof, busy} !== 2'b10)
      $display("FAIL stream_eof got eof=%b busy=%b want 1/0",
               sif.stream_eof, busy);
    else passed++;
    checks++;
    if (sif.stream_data !== 16'(BL - 1))
      $display("FAIL stream_last got %h want %h",
               sif.stream_data, 16'(BL - 1));
    else passed++;
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < BL; i++) begin
      step(0, 1, 16'(i), 0, 1);
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL ovf c%0d got %h want %h",
                 i, act_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if ({ovf, cnt} !== {1'b1, 16'(BL)})
      $display("FAIL ovf_flag got ovf=%b cnt=%0d want 1/%0d",
               ovf, cnt, BL);
    else passed++;
    for (int k = 0; k < 40 && ph != M_DONE; k++) begin
      step(0, 0, 0, 1, 1);
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL ovf_drain c%0d got %h want %h",
                 k, act_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if ({sif.stream_eof, sif.stream_data} !== {1'b1, 16'(DEPTH - 1)})
      $display("FAIL ovf_last got eof=%b data=%h want 1/%h",
               sif.stream_eof, sif.stream_data, 16'(DEPTH - 1));
    else passed++;
  endtask

  task automatic test_full_rw();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 16'(100 + i), 0, 1);
    step(0, 1, 16'hABCD, 1, 1);
    checks++;
    if ({ovf, sif.stream_empty} !== 2'b00)
      $display("FAIL full_rw got ovf=%b empty=%b want 0/0",
               ovf, sif.stream_empty);
    else passed++;
    checks++;
    if (act_vec() !== exp_vec())
      $display("FAIL full_rw_state got %h want %h", act_vec(), exp_vec());
    else passed++;
    for (int k = 0; k < 200 && ph != M_DONE; k++) begin
      step(0, ($urandom % 4) != 0, 16'($urandom),
           ($urandom % 3) != 0, 1);
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL full_rw_run c%0d got %h want %h",
                 k, act_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_close_mid();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 1, 16'($urandom), 0, 1);
    step(0, 1, 16'h5555, 1, 0);
    checks++;
    if ({sif.stream_empty, sif.stream_eof, busy} !== 3'b100)
      $display("FAIL close_mid got empty/eof/busy=%b want 100",
               {sif.stream_empty, sif.stream_eof, busy});
    else passed++;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    for (int k = 0; k < 200 && ph != M_DONE; k++) begin
      step(0, ($urandom % 2) != 0, 16'($urandom),
           ($urandom % 2) != 0, 1);
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL reopen c%0d got %h want %h",
                 k, act_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_ignored();
    logic [15:0] held;
    held = m_cnt;
    step(1, 0, 0, 0, 0);
    step(1, 1, 16'h1234, 0, 0);
    checks++;
    if ({busy, cnt} !== {1'b0, held})
      $display("FAIL start_closed got busy=%b cnt=%0d want 0/%0d",
               busy, cnt, held);
    else passed++;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < BL; i++) step(0, 1, 16'($urandom), 0, 1);
    step(1, 1, 16'h7777, 0, 1);
    checks++;
    if ({busy, sif.stream_eof, cnt} !== {2'b10, 16'(BL)})
      $display("FAIL start_drain got busy=%b eof=%b cnt=%0d",
               busy, sif.stream_eof, cnt);
    else passed++;
    checks++;
    if (act_vec() !== exp_vec())
      $display("FAIL start_drain_state got %h want %h",
               act_vec(), exp_vec());
    else passed++;
    for (int k = 0; k < 40 && ph != M_DONE; k++) begin
      step(0, 0, 0, 1, 1);
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL ign_drain c%0d got %h want %h",
                 k, act_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 3; b++) begin
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, ($urandom % 2) != 0, 1);
      for (int k = 0; k < 300 && ph != M_DONE; k++) begin
        step(0, ($urandom % 3) != 0, 16'($urandom),
             ($urandom % 4) != 0, 1);
        checks++;
        if (act_vec() !== exp_vec())
          $display("FAIL rand b%0d c%0d got %h want %h",
                   b, k, act_vec(), exp_vec());
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < BL; i++) step(0, 1, 16'(i + 3), 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act_vec() !== exp_vec())
      $display("FAIL async_rst got %h want %h", act_vec(), exp_vec());
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 1);
    checks++;
    if (act_vec() !== exp_vec())
      $display("FAIL post_rst got %h want %h", act_vec(), exp_vec());
    else passed++;
  endtask

  initial begin
    sif.stream_open = 1'b0;
    sif.stream_rden = 1'b0;
    test_reset();
    test_stream();
    test_overflow();
    test_full_rw();
    test_close_mid();
    test_ignored();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
